// File: rtl/ahb_timer_pkg.sv
// Shared definitions for the AHB timer slave: register offsets, CTRL/STATUS bit
// positions, AHB encodings and the data-phase FSM state type.
package ahb_timer_pkg;

   // Word offsets within the decoded HADDR window
   localparam logic [7:0] OffCtrl     = 8'h00;
   localparam logic [7:0] OffLoad     = 8'h04;
   localparam logic [7:0] OffValue    = 8'h08;
   localparam logic [7:0] OffStatus   = 8'h0C;
   localparam logic [7:0] OffPrescale = 8'h10;

   // CTRL and STATUS bit indices
   localparam int unsigned CtrlEnBit     = 0;
   localparam int unsigned CtrlIeBit     = 1;
   localparam int unsigned CtrlReloadBit = 2;
   localparam int unsigned StatusPendBit = 0;

   // Prescaler width when the prescaler is built in
   localparam int unsigned PrescaleW = 8;

   // AHB encodings
   localparam logic [1:0] HTransIdle   = 2'b00;
   localparam logic [1:0] HTransBusy   = 2'b01;
   localparam logic [1:0] HTransNonseq = 2'b10;
   localparam logic [1:0] HTransSeq    = 2'b11;
   localparam logic [1:0] HRespOkay    = 2'b00;
   localparam logic [1:0] HRespError   = 2'b01;
   localparam logic [2:0] HSizeWord    = 3'b010;

   // Data-phase FSM
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWait = 3'd1,
      StDone = 3'd2,
      StErr1 = 3'd3,
      StErr2 = 3'd4
   } ahb_state_e;

endpackage

// File: rtl/ahb_timer_core.sv
// Down-counter core: VALUE decrement, reload/stop on underflow and the PEND flag.
// Optional prescaler enabled by defining AHB_TIMER_PRESCALER_EN.
module ahb_timer_core
   import ahb_timer_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 en_i,
   input  logic                 reload_i,
   input  logic [31:0]          load_val_i,
   input  logic                 load_wr_i,
   input  logic [31:0]          load_wdata_i,
   input  logic                 pend_clr_i,
`ifdef AHB_TIMER_PRESCALER_EN
   input  logic [PrescaleW-1:0] prescale_i,
`endif
   output logic [31:0]          value_o,
   output logic                 pend_o,
   output logic                 en_clr_o
);

   logic        tick;
   logic [31:0] value_q, value_d;
   logic        pend_q, pend_d;
   logic        pend_set;

`ifdef AHB_TIMER_PRESCALER_EN
   logic [PrescaleW-1:0] pcnt_q, pcnt_d;

   // Prescale count: held at zero while disabled, so an EN 0->1 edge starts a fresh period;
   // >= guards against PRESCALE being lowered below the running count.
   always_comb begin
      pcnt_d = pcnt_q;
      tick   = 1'b0;
      if (!en_i) begin
         pcnt_d = '0;
      end else if (pcnt_q >= prescale_i) begin
         tick   = 1'b1;
         pcnt_d = '0;
      end else begin
         pcnt_d = pcnt_q + 1'b1;
      end
   end

   // Prescale counter register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end
`else
   // Without a prescaler every enabled cycle is a tick
   assign tick = en_i;
`endif

   // Counter next state: decrement, underflow handling, then bus LOAD write wins
   always_comb begin
      value_d  = value_q;
      pend_set = 1'b0;
      en_clr_o = 1'b0;
      if (tick) begin
         if (value_q == 32'd0) begin
            pend_set = 1'b1;
            if (reload_i) begin
               value_d = load_val_i;
            end else begin
               en_clr_o = 1'b1;
            end
         end else begin
            value_d = value_q - 32'd1;
         end
      end
      if (load_wr_i) begin
         value_d = load_wdata_i;
      end
      // Setting beats a simultaneous write-1-to-clear
      pend_d = pend_set | (pend_q & ~pend_clr_i);
   end

   // Counter and pending-flag registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         value_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         value_q <= value_d;
         pend_q  <= pend_d;
      end
   end

   assign value_o = value_q;
   assign pend_o  = pend_q;

endmodule

// File: rtl/ahb_timer_slave.sv
// AHB-Lite timer slave: data-phase FSM, register file and the timer core.
// Define AHB_TIMER_PRESCALER_EN to add the PRESCALE register at offset 0x10.
module ahb_timer_slave
   import ahb_timer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned ADDR_W      = 5
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic [1:0]  HRESP,
   output logic        IRQ
);

   localparam logic [2:0] WaitLast = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

   function automatic logic off_is(input logic [ADDR_W-1:0] a, input logic [7:0] off);
      return a == ADDR_W'(off);
   endfunction

   function automatic logic off_known(input logic [ADDR_W-1:0] a);
      logic k;
      k = off_is(a, OffCtrl) | off_is(a, OffLoad) | off_is(a, OffValue) | off_is(a, OffStatus);
`ifdef AHB_TIMER_PRESCALER_EN
      k = k | off_is(a, OffPrescale);
`endif
      return k;
   endfunction

   ahb_state_e        state_q, state_d;
   logic [2:0]        wait_cnt_q, wait_cnt_d;
   logic [ADDR_W-1:0] addr_q;
   logic              write_q;
   logic [2:0]        size_q;

   logic [ADDR_W-1:0] haddr_off;
   logic              accept;
   logic              req_err;

   logic              en_q, ie_q, reload_q;
   logic [31:0]       load_q;
   logic [31:0]       value;
   logic              pend;
   logic              en_clr;
   logic              wr_en, wr_ctrl, wr_load, wr_status;
   logic [31:0]       rdata;

   logic              unused_bus;
   assign unused_bus = ^{HADDR[31:ADDR_W], HTRANS[0]};

   assign haddr_off = HADDR[ADDR_W-1:0];
   assign accept    = HSEL & HTRANS[1] & HREADY;
   assign req_err   = (HSIZE != HSizeWord) | ~off_known(haddr_off)
                    | (HWRITE & off_is(haddr_off, OffValue));

   // FSM state and wait counter registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // FSM next state; DONE and ERR2 may take a new transfer with no idle gap
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StIdle, StDone, StErr2: begin
            if (accept) begin
               if (req_err) begin
                  state_d = StErr1;
               end else if (WAIT_STATES == 0) begin
                  state_d = StDone;
               end else begin
                  state_d    = StWait;
                  wait_cnt_d = WaitLast;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (wait_cnt_q == 3'd0) begin
               state_d = StDone;
            end else begin
               wait_cnt_d = wait_cnt_q - 3'd1;
            end
         end
         StErr1:  state_d = StErr2;
         default: state_d = StIdle;
      endcase
   end

   // FSM outputs; read data is only driven in DONE of a read
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = HRespOkay;
      HRDATA    = '0;
      unique case (state_q)
         StWait: HREADYOUT = 1'b0;
         StDone: begin
            if (!write_q) begin
               HRDATA = rdata;
            end
         end
         StErr1: begin
            HREADYOUT = 1'b0;
            HRESP     = HRespError;
         end
         StErr2:  HRESP = HRespError;
         default: ;
      endcase
   end

   // Address-phase capture
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= '0;
      end else if (accept) begin
         addr_q  <= haddr_off;
         write_q <= HWRITE;
         size_q  <= HSIZE;
      end
   end

   // Errored transfers never reach DONE, so a DONE write is always a legal one
   assign wr_en     = (state_q == StDone) & write_q & (size_q == HSizeWord);
   assign wr_ctrl   = wr_en & off_is(addr_q, OffCtrl);
   assign wr_load   = wr_en & off_is(addr_q, OffLoad);
   assign wr_status = wr_en & off_is(addr_q, OffStatus);

   // CTRL and LOAD registers; a bus CTRL write beats the core's EN clear
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         en_q     <= 1'b0;
         ie_q     <= 1'b0;
         reload_q <= 1'b0;
         load_q   <= '0;
      end else begin
         if (wr_ctrl) begin
            en_q     <= HWDATA[CtrlEnBit];
            ie_q     <= HWDATA[CtrlIeBit];
            reload_q <= HWDATA[CtrlReloadBit];
         end else if (en_clr) begin
            en_q <= 1'b0;
         end
         if (wr_load) begin
            load_q <= HWDATA;
         end
      end
   end

`ifdef AHB_TIMER_PRESCALER_EN
   logic [PrescaleW-1:0] prescale_q;
   logic                 wr_prescale;
   assign wr_prescale = wr_en & off_is(addr_q, OffPrescale);

   // PRESCALE register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         prescale_q <= '0;
      end else if (wr_prescale) begin
         prescale_q <= HWDATA[PrescaleW-1:0];
      end
   end
`endif

   // Read mux for the data-phase address
   always_comb begin
      rdata = '0;
      if (off_is(addr_q, OffCtrl)) begin
         rdata[CtrlEnBit]     = en_q;
         rdata[CtrlIeBit]     = ie_q;
         rdata[CtrlReloadBit] = reload_q;
      end else if (off_is(addr_q, OffLoad)) begin
         rdata = load_q;
      end else if (off_is(addr_q, OffValue)) begin
         rdata = value;
      end else if (off_is(addr_q, OffStatus)) begin
         rdata[StatusPendBit] = pend;
`ifdef AHB_TIMER_PRESCALER_EN
      end else if (off_is(addr_q, OffPrescale)) begin
         rdata[PrescaleW-1:0] = prescale_q;
`endif
      end
   end

   ahb_timer_core u_core (
      .clk_i        (HCLK),
      .rst_ni       (HRESETn),
      .en_i         (en_q),
      .reload_i     (reload_q),
      .load_val_i   (load_q),
      .load_wr_i    (wr_load),
      .load_wdata_i (HWDATA),
      .pend_clr_i   (wr_status & HWDATA[StatusPendBit]),
`ifdef AHB_TIMER_PRESCALER_EN
      .prescale_i   (prescale_q),
`endif
      .value_o      (value),
      .pend_o       (pend),
      .en_clr_o     (en_clr)
   );

   assign IRQ = pend & ie_q;

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Bench for ahb_timer_slave (default build, no prescaler). The driver predicts each
// transfer's response from a cycle-level timer model and queues it; a monitor checks
// bus outputs and IRQ every cycle against the queue and the model.
module tb_ahb_timer_slave;

   localparam int W = 1;

   logic        HCLK = 1'b0;
   logic        HRESETn, HSEL, HWRITE, HREADY, HREADYOUT, IRQ;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS, HRESP;
   logic [2:0]  HSIZE;

   assign HREADY = HREADYOUT;
   always #5 HCLK = ~HCLK;

   ahb_timer_slave #(.WAIT_STATES(W), .ADDR_W(5)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HRDATA    (HRDATA),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .IRQ       (IRQ)
   );

   typedef struct packed {
      logic        en, ie, reload, pend;
      logic [31:0] load, value;
   } tstate_t;

   typedef struct {
      int          start;
      int          done;
      logic [1:0]  resp;
      bit          chk_data;
      logic [31:0] rdata;
   } exp_t;

   exp_t        exp_q[$];
   tstate_t     mdl = '0;
   int          cyc = 0;
   int          next_free = 0;
   int          n_cmp = 0, n_err = 0;
   bit          cw_valid[int];
   logic [4:0]  cw_off[int];
   logic [31:0] cw_data[int];

   // Timer behaviour for one clock, with an optional bus write landing on that edge
   function automatic tstate_t step(tstate_t s, bit wr, logic [4:0] off, logic [31:0] d);
      tstate_t n = s;
      bit set_p = 0;
      if (s.en) begin
         if (s.value == 0) begin
            set_p  = 1;
            n.pend = 1;
            if (s.reload) n.value = s.load;
            else n.en = 0;
         end else begin
            n.value = s.value - 1;
         end
      end
      if (wr) begin
         if (off == 5'h00) begin
            n.en = d[0]; n.ie = d[1]; n.reload = d[2];
         end else if (off == 5'h04) begin
            n.load = d; n.value = d;
         end else if (off == 5'h0C && d[0] && !set_p) begin
            n.pend = 0;
         end
      end
      return n;
   endfunction

   // Model state n cycles ahead of the current one, including scheduled writes
   function automatic tstate_t predict(int n);
      tstate_t s = mdl;
      for (int k = 0; k < n; k++) begin
         int e = cyc + k;
         if (cw_valid.exists(e)) s = step(s, 1, cw_off[e], cw_data[e]);
         else s = step(s, 0, 5'h0, 32'h0);
      end
      return s;
   endfunction

   function automatic logic [31:0] rd(tstate_t s, logic [4:0] off);
      case (off)
         5'h00:   return {29'b0, s.reload, s.ie, s.en};
         5'h04:   return s.load;
         5'h08:   return s.value;
         5'h0C:   return {31'b0, s.pend};
         default: return 32'h0;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
      end
   endtask

   // Model advance and cycle count
   always @(posedge HCLK) begin
      if (!HRESETn) mdl <= '0;
      else if (cw_valid.exists(cyc)) mdl <= step(mdl, 1, cw_off[cyc], cw_data[cyc]);
      else mdl <= step(mdl, 0, 5'h0, 32'h0);
      cyc <= cyc + 1;
   end

   // Monitor: compare DUT outputs mid-cycle
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
         chk("rst_hresp", 32'(HRESP), 32'd0);
         chk("rst_hrdata", HRDATA, 32'd0);
         chk("rst_irq", 32'(IRQ), 32'd0);
      end else begin
         if (exp_q.size() > 0 && cyc >= exp_q[0].start) begin
            if (cyc < exp_q[0].done) begin
               chk("wait_hreadyout", 32'(HREADYOUT), 32'd0);
               chk("wait_hresp", 32'(HRESP), 32'(exp_q[0].resp));
            end else begin
               chk("done_hreadyout", 32'(HREADYOUT), 32'd1);
               chk("done_hresp", 32'(HRESP), 32'(exp_q[0].resp));
               if (exp_q[0].chk_data) chk("rdata", HRDATA, exp_q[0].rdata);
               void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
            chk("idle_hresp", 32'(HRESP), 32'd0);
            chk("idle_hrdata", HRDATA, 32'd0);
         end
         chk("irq", 32'(IRQ), 32'(mdl.pend & mdl.ie));
      end
   end

   task automatic clk1;
      @(posedge HCLK);
      #1;
   endtask

   // One cycle with no transfer to this slave; noise drives non-accepted requests
   task automatic idle_cycle(input bit noise);
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      if (noise && $urandom_range(0, 2) == 0) begin
         HWRITE = 1'b1;
         HSIZE  = 3'b010;
         HADDR  = {27'($urandom()), 5'($urandom_range(0, 3) * 4)};
         if ($urandom_range(0, 1) == 1) begin
            HTRANS = 2'b10;
         end else begin
            HSEL   = 1'b1;
            HTRANS = 2'b01;
         end
      end
      clk1();
   endtask

   task automatic issue(input bit wr, input logic [4:0] off, input logic [2:0] sz,
                        input logic [31:0] d, input int gap, input bit noise);
      int c, dn;
      bit err;
      exp_t e;
      while (cyc < next_free + gap) idle_cycle(noise);
      c   = cyc;
      err = (sz != 3'b010) || !(off inside {5'h00, 5'h04, 5'h08, 5'h0C}) || (wr && off == 5'h08);
      dn  = err ? c + 2 : c + 1 + W;
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HSIZE  = sz;
      HADDR  = {27'($urandom()), off};
      e.start    = c + 1;
      e.done     = dn;
      e.resp     = err ? 2'b01 : 2'b00;
      e.chk_data = !wr && !err;
      e.rdata    = e.chk_data ? rd(predict(dn - c), off) : 32'h0;
      if (wr && !err) begin
         cw_valid[dn] = 1;
         cw_off[dn]   = off;
         cw_data[dn]  = d;
      end
      exp_q.push_back(e);
      next_free = dn;
      clk1();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWDATA = d;
   endtask

   // Idle until a transfer issued now would commit on an underflow edge
   task automatic idle_until_uf;
      tstate_t s;
      bit found = 0;
      for (int k = 0; k < 64 && !found; k++) begin
         if (cyc >= next_free) begin
            s = predict(1 + W);
            if (s.en && s.value == 0) found = 1;
         end
         if (!found) idle_cycle(0);
      end
      chk("underflow_align", 32'(found), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
      $fatal(1);
   end

   initial begin
      logic [4:0]  off;
      logic [31:0] d;
      HRESETn = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
      HSIZE = 3'b010; HADDR = '0; HWDATA = '0;
      repeat (3) clk1();
      HRESETn = 1'b1;
      next_free = cyc;

      // Reset value of VALUE with one wait state
      issue(0, 5'h08, 3'b010, 0, 0, 0);
      // Auto-reload count 3,2,1,0,3 with IRQ
      issue(1, 5'h04, 3'b010, 32'd3, 1, 0);
      issue(1, 5'h00, 3'b010, 32'h7, 0, 0);
      repeat (5) issue(0, 5'h08, 3'b010, 0, 0, 0);
      issue(0, 5'h0C, 3'b010, 0, 0, 0);
      // W1C on the underflow edge keeps PEND; later W1C clears it
      idle_until_uf();
      issue(1, 5'h0C, 3'b010, 32'h1, 0, 0);
      issue(0, 5'h0C, 3'b010, 0, 0, 0);
      issue(1, 5'h00, 3'b010, 32'h2, 0, 0);
      issue(1, 5'h0C, 3'b010, 32'h1, 0, 0);
      issue(0, 5'h0C, 3'b010, 0, 0, 0);
      // One-shot: VALUE stops at 0, EN clears, PEND set
      issue(1, 5'h04, 3'b010, 32'd2, 0, 0);
      issue(1, 5'h00, 3'b010, 32'h3, 0, 0);
      repeat (8) idle_cycle(0);
      issue(0, 5'h00, 3'b010, 0, 0, 0);
      issue(0, 5'h08, 3'b010, 0, 0, 0);
      issue(0, 5'h0C, 3'b010, 0, 0, 0);
      // Error responses leave registers alone
      issue(0, 5'h08, 3'b000, 0, 0, 0);
      issue(0, 5'h14, 3'b010, 0, 0, 0);
      issue(1, 5'h08, 3'b010, 32'hDEAD, 0, 0);
      issue(0, 5'h10, 3'b010, 0, 0, 0);
      issue(1, 5'h04, 3'b001, 32'h99, 0, 0);
      issue(0, 5'h04, 3'b010, 0, 0, 0);
      issue(0, 5'h00, 3'b010, 0, 0, 0);
      // Reset during the wait state of a LOAD write
      issue(1, 5'h04, 3'b010, 32'h55, 1, 0);
      exp_q.delete(); cw_valid.delete(); cw_off.delete(); cw_data.delete();
      HRESETn = 1'b0;
      repeat (2) clk1();
      HRESETn = 1'b1;
      next_free = cyc;
      issue(0, 5'h04, 3'b010, 0, 0, 0);
      issue(0, 5'h00, 3'b010, 0, 0, 0);

      // Randomized traffic
      for (int i = 0; i < 200; i++) begin
         case ($urandom_range(0, 7))
            0:       off = 5'h00;
            1, 5:    off = 5'h04;
            2:       off = 5'h08;
            3, 4:    off = 5'h0C;
            6:       off = 5'h10;
            default: off = 5'($urandom());
         endcase
         d = (off == 5'h04) ? 32'($urandom_range(0, 12)) : $urandom();
         issue(1'($urandom_range(0, 1)), off,
               ($urandom_range(0, 9) == 0) ? 3'($urandom()) : 3'b010,
               d, $urandom_range(0, 2), 1);
      end
      repeat (4) idle_cycle(0);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ahb_timer_slave.md
AHB_TIMER_SLAVE -- requirements
Module: ahb_timer_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 1, data-phase wait cycles per valid OKAY transfer (0..7).
REQ-002 SHALL have parameter ADDR_W, default 5, number of HADDR bits decoded.
REQ-003 SHALL have port HCLK  in  1  sole clock, rising edge.
REQ-004 SHALL have port HRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports HSEL in 1, HADDR in 32, HTRANS in 2, HWRITE in 1, HSIZE in 3, HWDATA in 32, with standard AHB meanings.
REQ-006 SHALL have port HREADY  in  1  bus-wide ready, fed back from the slave-to-master mux.
REQ-007 SHALL have ports HRDATA out 32, HREADYOUT out 1, HRESP out 2, to one slave slot of the slave-to-master mux.
REQ-008 SHALL have port IRQ  out  1  timer interrupt, level.

Function
REQ-009 SHALL accept a transfer only when HSEL & HTRANS[1] & HREADY; it latches HADDR[ADDR_W-1:0], HWRITE and HSIZE.
REQ-010 SHALL decode word offsets: 0x00 CTRL (bit0 EN, bit1 IE, bit2 RELOAD), 0x04 LOAD, 0x08 VALUE (RO), 0x0C STATUS (bit0 PEND, write-1-to-clear).
REQ-011 SHALL treat as an error any HSIZE other than 3'b010, any undecoded offset, or a write to VALUE.
REQ-012 SHALL run the data-phase FSM IDLE -> WAIT (WAIT_STATES cycles, HREADYOUT=0, HRESP=OKAY) -> DONE (HREADYOUT=1, OKAY); with WAIT_STATES=0 it goes directly to DONE.
REQ-013 SHALL answer errors with ERR1 (HREADYOUT=0, HRESP=ERROR) then ERR2 (HREADYOUT=1, HRESP=ERROR); no register changes.
REQ-014 SHALL drive HREADYOUT=1, HRESP=OKAY and HRDATA=0 in IDLE.
REQ-015 SHALL accept a new transfer in the DONE/ERR2 cycle, so back-to-back transfers have no idle gap.
REQ-016 SHALL commit write data from HWDATA in the DONE cycle only.
REQ-017 SHALL present read data in the DONE cycle only; unused bits SHALL read 0.
REQ-018 SHALL load VALUE from HWDATA whenever LOAD is written.
REQ-019 SHALL, while EN=1 and on each tick, decrement VALUE, 32-bit unsigned.
REQ-020 SHALL, on a tick with VALUE==0, set PEND; if RELOAD=1 it loads VALUE=LOAD, else it clears EN and holds VALUE=0.
REQ-021 SHALL give set priority when a PEND set and a STATUS W1C fall in the same cycle, so PEND stays 1.
REQ-022 SHALL give the bus write priority when a LOAD write and a counter decrement fall in the same cycle.
REQ-023 SHALL drive IRQ = PEND & IE, registered-state combinational.

Reset
REQ-024 SHALL, while HRESETn=0, drive FSM=IDLE, CTRL=0, LOAD=0, VALUE=0, PEND=0, IRQ=0, HREADYOUT=1, HRESP=OKAY, HRDATA=0.
REQ-025 SHALL abandon any in-flight transfer on reset mid-transfer, with no register write.

Configuration
REQ-026 SHALL, when AHB_TIMER_PRESCALER_EN is defined, add PRESCALE (8-bit RW, reset 0) at offset 0x10; a tick occurs every PRESCALE+1 cycles, and the prescale counter clears on EN 0->1.
REQ-027 SHALL, when AHB_TIMER_PRESCALER_EN is undefined, tick every cycle; offset 0x10 is an error.

Structure
REQ-028 SHALL place the register offsets, CTRL bit indices, HTRANS/HRESP encodings and FSM state enum in shared package ahb_timer_pkg.
REQ-029 SHALL implement the counter/reload/PEND logic in one sub-module, ahb_timer_core; the AHB interface FSM and register file stay in the top.

Verification
REQ-030 SHALL cover: reset, then read 0x08 with WAIT_STATES=1 -> one HREADYOUT=0 cycle, then HRDATA=0x0, OKAY.
REQ-031 SHALL cover: write LOAD=3, CTRL=0x7 -> VALUE 3,2,1,0,3; PEND=1 and IRQ=1 on the cycle after VALUE==0.
REQ-032 SHALL cover: RELOAD=0, LOAD=2, EN=1 -> VALUE stops at 0, CTRL reads 0x2 (IE only), PEND=1.
REQ-033 SHALL cover: W1C to STATUS in the same cycle as an underflow -> PEND remains 1; a later W1C -> PEND=0, IRQ=0.
REQ-034 SHALL cover: read with HSIZE=3'b000, then read offset 0x14 -> each gets ERROR,HREADYOUT=0 then ERROR,HREADYOUT=1; registers unchanged.
REQ-035 SHALL cover: HRESETn low during WAIT of a LOAD=0x55 write -> LOAD=0, HREADYOUT=1 while in reset.
